// File: rtl/pe_modarith_pipe.sv
// pe_modarith_pipe: NUM-lane modular add/sub/round datapath for the PQC PE.
// Two registered stages with valid/ready on both sides. Stage 1 forms a raw
// WIDTH+1 bit result per lane; stage 2 reduces/formats it into y.
// Optional build macro: PE_RANGE_CHECK_EN adds per-lane operand range flags
// that travel with the beat onto out_err_o; without it out_err_o is tied low.
module pe_modarith_pipe #(
    parameter int NUM   = 4,
    parameter int WIDTH = 24,
    parameter int Q_KEM = 3329,
    parameter int Q_DSA = 8380417,
    parameter int D     = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             op_i,
    input  logic                   q_sel_i,
    input  logic [WIDTH-1:0]       thr_i,
    input  logic [NUM*WIDTH-1:0]   a_i,
    input  logic [NUM*WIDTH-1:0]   b_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [NUM*WIDTH-1:0]   y_o,
    output logic [2:0]             out_op_o,
    output logic [NUM-1:0]         out_err_o
);

    localparam int RW = WIDTH + 1;
    localparam logic [RW-1:0] QK_W       = RW'(Q_KEM);
    localparam logic [RW-1:0] QD_W       = RW'(Q_DSA);
    localparam logic [RW-1:0] P2R_ADD_W  = RW'((32'd1 << (D - 1)) - 32'd1);
    localparam logic [RW-1:0] DCP1_ADD_W = RW'(32'd127);

    typedef enum logic [2:0] {
        OP_MADD = 3'd0,
        OP_MSUB = 3'd1,
        OP_P2R  = 3'd2,
        OP_DCP1 = 3'd3,
        OP_CHKN = 3'd4
    } op_e;

    // Stage 1 raw value; MSUB adds Q first so the result stays non-negative.
    function automatic logic [RW-1:0] fn_raw(input logic [2:0] op,
                                             input logic [RW-1:0] q,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [RW-1:0] r;
        r = {RW{1'b0}};
        case (op)
            OP_MADD: r = {1'b0, a} + {1'b0, b};
            OP_MSUB: r = {1'b0, a} + q - {1'b0, b};
            OP_P2R:  r = {1'b0, a} + P2R_ADD_W;
            OP_DCP1: r = {1'b0, a} + DCP1_ADD_W;
            OP_CHKN: r = {1'b0, a};
            default: r = {RW{1'b0}};
        endcase
        return r;
    endfunction

    // Stage 2 reduction/format; reserved ops produce zero.
    function automatic logic [WIDTH-1:0] fn_fmt(input logic [2:0] op,
                                                input logic [RW-1:0] q,
                                                input logic [WIDTH-1:0] thr,
                                                input logic [RW-1:0] r);
        logic [RW-1:0]    half;
        logic [RW-1:0]    c;
        logic [WIDTH-1:0] res;
        half = (q - {{(RW-1){1'b0}}, 1'b1}) >> 1;
        c    = (r > half) ? (q - r) : r;
        res  = {WIDTH{1'b0}};
        case (op)
            OP_MADD, OP_MSUB: res = (r >= q) ? WIDTH'(r - q) : WIDTH'(r);
            OP_P2R:           res = WIDTH'(r >> D);
            OP_DCP1:          res = WIDTH'(r >> 3'd7);
            OP_CHKN:          res = {{(WIDTH-1){1'b0}}, (c >= {1'b0, thr})};
            default:          res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    logic                      s1_v_q;
    logic [2:0]                s1_op_q;
    logic                      s1_qsel_q;
    logic [WIDTH-1:0]          s1_thr_q;
    logic [NUM-1:0][RW-1:0]    s1_r_q;
    logic [NUM-1:0][RW-1:0]    s1_r_d;
    logic                      out_valid_q;
    logic [NUM*WIDTH-1:0]      y_q;
    logic [NUM*WIDTH-1:0]      y_d;
    logic [2:0]                out_op_q;
    logic                      s1_load_s;
    logic                      s2_load_s;
    logic                      accept_s;
    logic [RW-1:0]             q_in_s;
    logic [RW-1:0]             q_s1_s;

    // A stage loads when empty or when its current content leaves this cycle.
    assign s2_load_s = !out_valid_q | out_ready_i;
    assign s1_load_s = !s1_v_q | s2_load_s;
    assign accept_s  = in_valid_i & s1_load_s;
    assign in_ready_o = s1_load_s;

    assign q_in_s = q_sel_i   ? QD_W : QK_W;
    assign q_s1_s = s1_qsel_q ? QD_W : QK_W;

    // Per-lane raw results for the incoming beat.
    always_comb begin
        s1_r_d = {(NUM*RW){1'b0}};
        for (int i = 0; i < NUM; i++) begin
            s1_r_d[i] = fn_raw(op_i, q_in_s, a_i[i*WIDTH +: WIDTH], b_i[i*WIDTH +: WIDTH]);
        end
    end

    // Per-lane reduced results for the beat held in stage 1.
    always_comb begin
        y_d = {(NUM*WIDTH){1'b0}};
        for (int i = 0; i < NUM; i++) begin
            y_d[i*WIDTH +: WIDTH] = fn_fmt(s1_op_q, q_s1_s, s1_thr_q, s1_r_q[i]);
        end
    end

    // Stage 1 register: captures the beat only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= 3'd0;
            s1_qsel_q <= 1'b0;
            s1_thr_q  <= {WIDTH{1'b0}};
            s1_r_q    <= {(NUM*RW){1'b0}};
        end else if (s1_load_s) begin
            s1_v_q <= accept_s;
            if (accept_s) begin
                s1_op_q   <= op_i;
                s1_qsel_q <= q_sel_i;
                s1_thr_q  <= thr_i;
                s1_r_q    <= s1_r_d;
            end
        end
    end

    // Stage 2 / output register: y and out_op hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= {(NUM*WIDTH){1'b0}};
            out_op_q    <= 3'd0;
        end else if (s2_load_s) begin
            out_valid_q <= s1_v_q;
            if (s1_v_q) begin
                y_q      <= y_d;
                out_op_q <= s1_op_q;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign out_op_o    = out_op_q;

`ifdef PE_RANGE_CHECK_EN
    logic [NUM-1:0] s1_err_d;
    logic [NUM-1:0] s1_err_q;
    logic [NUM-1:0] out_err_q;

    // Flag lanes whose operands are not reduced modulo the selected Q.
    always_comb begin
        s1_err_d = {NUM{1'b0}};
        for (int i = 0; i < NUM; i++) begin
            if ((op_i == OP_MADD) || (op_i == OP_MSUB)) begin
                s1_err_d[i] = ({1'b0, a_i[i*WIDTH +: WIDTH]} >= q_in_s) |
                              ({1'b0, b_i[i*WIDTH +: WIDTH]} >= q_in_s);
            end else begin
                s1_err_d[i] = ({1'b0, a_i[i*WIDTH +: WIDTH]} >= q_in_s);
            end
        end
    end

    // Range flags follow the beat through both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err_q  <= {NUM{1'b0}};
            out_err_q <= {NUM{1'b0}};
        end else begin
            if (s1_load_s && accept_s) begin
                s1_err_q <= s1_err_d;
            end
            if (s2_load_s && s1_v_q) begin
                out_err_q <= s1_err_q;
            end
        end
    end

    assign out_err_o = out_err_q;
`else
    assign out_err_o = {NUM{1'b0}};
`endif

endmodule

// File: tb/tb_pe_modarith_pipe.sv
// Randomised + directed bench for pe_modarith_pipe, checked against an
// arithmetic reference model and an in-order scoreboard of expected beats.
module tb_pe_modarith_pipe;

    localparam int NUM   = 4;
    localparam int WIDTH = 24;
    localparam longint QK = 3329;
    localparam longint QD = 8380417;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic                 q_sel;
    logic [WIDTH-1:0]     thr;
    logic [NUM*WIDTH-1:0] a;
    logic [NUM*WIDTH-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM*WIDTH-1:0] y;
    logic [2:0]           out_op;
    logic [NUM-1:0]       out_err;

    always #5 clk = ~clk;

    pe_modarith_pipe #(.NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .q_sel_i(q_sel), .thr_i(thr), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .y_o(y), .out_op_o(out_op), .out_err_o(out_err)
    );

    typedef struct {
        logic [NUM*WIDTH-1:0] y;
        logic [2:0]           op;
        logic [NUM-1:0]       err;
        int                   cyc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit lat_chk  = 1'b0;
    bit rand_ready = 1'b0;
    int stall_left = 0;
    int ready_low_seen = 0;
    bit prev_stall = 1'b0;
    logic [NUM*WIDTH-1:0] prev_y;
    logic [2:0] prev_op;
    bit last_acc;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-lane result straight from the arithmetic definition of each op.
    function automatic longint ref_lane(input int o, input longint q, input longint t,
                                        input longint av, input longint bv);
        longint c;
        case (o)
            0: return (av + bv) % q;
            1: return (av - bv + q) % q;
            2: return (av + (64'd1 << 12) - 1) / 8192;
            3: return (av + 127) / 128;
            4: begin
                c = (av > (q - 1) / 2) ? q - av : av;
                return (c >= t) ? 1 : 0;
            end
            default: return 0;
        endcase
    endfunction

    function automatic exp_t ref_beat();
        exp_t e;
        longint q, av, bv, r;
        e.op = op; e.err = '0; e.y = '0; e.cyc = 0;
        q = q_sel ? QD : QK;
        for (int i = 0; i < NUM; i++) begin
            av = longint'(a[i*WIDTH +: WIDTH]);
            bv = longint'(b[i*WIDTH +: WIDTH]);
            r  = ref_lane(int'(op), q, longint'(thr), av, bv);
            e.y[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
`ifdef PE_RANGE_CHECK_EN
            e.err[i] = (av >= q) || ((op == 3'd0 || op == 3'd1) && bv >= q);
`endif
        end
        return e;
    endfunction

    function automatic logic [NUM*WIDTH-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
        logic [NUM*WIDTH-1:0] v;
        v = '0;
        v[0*WIDTH +: WIDTH] = WIDTH'(l0);
        v[1*WIDTH +: WIDTH] = WIDTH'(l1);
        v[2*WIDTH +: WIDTH] = WIDTH'(l2);
        v[3*WIDTH +: WIDTH] = WIDTH'(l3);
        return v;
    endfunction

    // One clock: pick out_ready, sample/score the handshake, then advance.
    task automatic step();
        exp_t e;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
        #1;
        last_acc = 1'b0;
        if (!rst) begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_y", y, prev_y);
                check_eq("hold_op", out_op, prev_op);
            end
            check_eq("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
            if (!in_ready) ready_low_seen++;
            if (out_valid && out_ready) begin
                check_eq("emit_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("y", y, e.y);
                    check_eq("out_op", out_op, e.op);
                    check_eq("out_err", out_err, e.err);
                    if (lat_chk) check_eq("latency", cyc - e.cyc, 2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y  = y;
            prev_op = out_op;
            if (in_valid && in_ready) begin
                e = ref_beat();
                e.cyc = cyc;
                sb.push_back(e);
                last_acc = 1'b1;
            end
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (rst) sb.delete();
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic qs, input logic [WIDTH-1:0] t,
                        input logic [NUM*WIDTH-1:0] av, input logic [NUM*WIDTH-1:0] bv);
        op = o; q_sel = qs; thr = t; a = av; b = bv; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_acc) break;
        end
        check_eq("accept_timeout", last_acc, 1'b1);
        in_valid = 1'b0;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        op = 3'($urandom);
    endtask

    task automatic send_rand();
        logic [2:0] o;
        logic qs;
        longint q;
        logic [NUM*WIDTH-1:0] av, bv;
        o  = 3'($urandom_range(0, 7));
        qs = 1'($urandom_range(0, 1));
        q  = qs ? QD : QK;
        for (int i = 0; i < NUM; i++) begin
            av[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, int'(q - 1)));
            bv[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, int'(q - 1)));
        end
        send(o, qs, WIDTH'($urandom_range(0, int'(q / 2 + 1))), av, bv);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_ready = 1'b0;
        stall_left = 0;
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        check_eq("drain_empty", sb.size(), 0);
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; q_sel = 1'b0; thr = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_y", y, '0);
        check_eq("rst_out_op", out_op, 3'd0);
        check_eq("rst_out_err", out_err, '0);
        rst = 1'b0;

        // Directed vectors with a free-running consumer.
        lat_chk = 1'b1;
        send(3'd0, 1'b0, '0, lanes(3000, 0, 3328, 1234), lanes(1000, 0, 3328, 2095));
        send(3'd1, 1'b1, '0, lanes(5, 7, 0, 8380416), lanes(10, 7, 8380416, 0));
        send(3'd2, 1'b1, '0, lanes(8191, 8192, 8380416, 4096), lanes(1, 2, 3, 4));
        send(3'd2, 1'b1, '0, lanes(4097, 0, 12287, 12288), lanes(0, 0, 0, 0));
        send(3'd3, 1'b0, '0, lanes(0, 1, 128, 3328), lanes(0, 0, 0, 0));
        send(3'd4, 1'b1, 24'd100, lanes(8380317, 99, 8380318, 100), lanes(0, 0, 0, 0));
        send(3'd4, 1'b0, 24'd1664, lanes(1664, 1665, 1663, 1666), lanes(0, 0, 0, 0));
        send(3'd5, 1'b0, 24'd5, lanes(10, 20, 30, 40), lanes(1, 2, 3, 4));
        send(3'd7, 1'b1, 24'd5, lanes(10, 20, 30, 40), lanes(1, 2, 3, 4));
        drain();

        // Random back-to-back beats, consumer always ready.
        for (int n = 0; n < 60; n++) send_rand();
        drain();

        // Consumer stalls 3 cycles while 5 beats are pushed back-to-back.
        lat_chk = 1'b0;
        ready_low_seen = 0;
        stall_left = 3;
        for (int n = 0; n < 5; n++) send_rand();
        drain();
        check_eq("t5_ready_dropped", ready_low_seen > 0, 1'b1);

        // Random backpressure and idle gaps.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();

        // Reset with two beats in flight: both must vanish.
        send(3'd0, 1'b0, '0, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8));
        send(3'd1, 1'b0, '0, lanes(9, 9, 9, 9), lanes(1, 1, 1, 1));
        rst = 1'b1;
        step();
        check_eq("t6_out_valid", out_valid, 1'b0);
        check_eq("t6_y", y, '0);
        check_eq("t6_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        repeat (5) step();
        check_eq("t6_no_stale", out_valid, 1'b0);

`ifdef PE_RANGE_CHECK_EN
        lat_chk = 1'b1;
        send(3'd0, 1'b0, '0, lanes(3329, 3328, 0, 5), lanes(0, 3329, 0, 5));
        send(3'd2, 1'b1, '0, lanes(8380417, 0, 0, 0), lanes(8380417, 0, 0, 0));
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
